frame_dispatch: RTL
===================

FRAME_DISPATCH -- requirements
Module: frame_dispatch

Interface
REQ-001 Parameters (name, default, meaning): ADDR_WIDTH, 12, frame address width; CORE_LAT, 4, butterfly pipeline latency added to the per-stage core count; TIMEOUT_CYC, 65535, maximum cycles spent waiting for end_fft.
REQ-002 Clock and reset SHALL be a single clock `clk` and an asynchronous, active-low reset `rst_n`.
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- enable  in  1  run request.
- fft_size_sel  in  4  log2 of the FFT size N.
- sample_valid  in  1  one input sample present this cycle.
- wr_ena  out  1  frame-buffer write strobe.
- wr_addr  out  ADDR_WIDTH  frame-buffer write address.
- ena_fft  out  1  one-cycle FFT launch pulse.
- max_point_fft  out  ADDR_WIDTH  N-1.
- max_point_fft_core  out  16  N/2-1+CORE_LAT.
- stage_number  out  4  log2 N.
- end_fft  in  1  FFT-complete pulse.
- busy  out  1  FFT in progress.
- overflow  out  1  sticky: a sample was dropped.
- timeout_err  out  1  sticky: end_fft never arrived.
- frame_cnt  out  16  frames launched.

Function
REQ-004 The FSM SHALL have states IDLE, FILL, LAUNCH, BUSY.
- IDLE->FILL when enable=1.
- FILL->LAUNCH when the N-th sample is written.
- LAUNCH->BUSY unconditionally after 1 cycle.
- BUSY->FILL on end_fft, or on timeout, when enable=1.
- BUSY->IDLE on end_fft, or on timeout, when enable=0.
REQ-005 fft_size_sel SHALL be captured on every entry to FILL and held for the whole frame.
- Values below 3 clamp to 3.
- Values above ADDR_WIDTH clamp to ADDR_WIDTH.
REQ-006 Configuration outputs SHALL be registered from the captured value s:
- stage_number=s.
- max_point_fft=2^s-1.
- max_point_fft_core=2^(s-1)-1+CORE_LAT, zero-extended to 16 bits.
- All three are stable from the cycle after FILL entry until the next FILL entry.
REQ-007 In FILL, sample_valid=1 SHALL produce wr_ena=1 and wr_addr=current count on the following cycle (1-cycle latency).
- The count increments per sample, starting at 0 on FILL entry.
REQ-008 Write N-1 SHALL cause the transition to LAUNCH.
- ena_fft=1 for exactly the LAUNCH cycle.
- frame_cnt increments in the same cycle, wrapping 0xFFFF->0.
REQ-009 sample_valid=1 in LAUNCH or BUSY SHALL drop the sample (no wr_ena) and set overflow.
- sample_valid=1 in IDLE SHALL be ignored without setting overflow.
REQ-010 busy SHALL be 1 in LAUNCH and BUSY, and 0 otherwise.
REQ-011 A 16-bit wait counter SHALL clear on BUSY entry and increment each BUSY cycle.
- Reaching TIMEOUT_CYC sets timeout_err and exits BUSY as per REQ-004.
REQ-012 end_fft SHALL be ignored outside BUSY.
- end_fft and timeout in the same cycle count as normal completion; timeout_err is not set.
REQ-013 enable falling during FILL SHALL return the FSM to IDLE next cycle and discard the partial frame.
- enable falling during BUSY SHALL take effect only at completion.
REQ-014 overflow and timeout_err SHALL clear only on reset, or on an IDLE->FILL transition.

Reset
REQ-015 Asserting rst_n=0 SHALL immediately force:
- state IDLE.
- wr_ena=0, wr_addr=0, ena_fft=0, busy=0.
- overflow=0, timeout_err=0, frame_cnt=0.
- stage_number=3, max_point_fft=7, max_point_fft_core=3+CORE_LAT.
REQ-016 Reset mid-frame or mid-FFT SHALL abandon all progress; no ena_fft is issued after release until a full new frame is written.

Configuration
REQ-017 Macro DROP_COUNT_EN selects the dropped-sample counter.
- Defined: an extra output drop_cnt[15:0] counts every sample dropped per REQ-009. It saturates at 0xFFFF and clears with overflow.
- Undefined: the port and its logic are absent, and all other behaviour is identical.

Verification
REQ-018 A bench SHALL cover these directed scenarios:
- Reset, sel=6, enable=1, 64 consecutive samples: wr_addr 0..63, then one ena_fft pulse; stage_number=6, max_point_fft=63, max_point_fft_core=31+CORE_LAT; frame_cnt=1.
- sel=1, then sel=15 with ADDR_WIDTH=12: stage_number clamps to 3, then to 12; max_point_fft=7, then 4095.
- 5 samples during BUSY, then end_fft: no wr_ena, overflow=1, next frame starts at wr_addr 0; with DROP_COUNT_EN, drop_cnt=5.
- TIMEOUT_CYC=20, end_fft withheld: timeout_err=1 after 20 BUSY cycles, FSM returns to FILL; end_fft on cycle 20 leaves timeout_err=0.
- enable dropped after 10 of 64 samples, then re-asserted: FSM goes to IDLE, the next frame restarts at wr_addr 0, and the only ena_fft comes after 64 fresh samples.
- rst_n pulsed mid-BUSY: all outputs reach reset values asynchronously; a late end_fft is ignored.

Source files
------------

// File: rtl/frame_dispatch.sv
// frame_dispatch: collects one frame of N = 2^s samples into a frame buffer,
// launches the FFT with a single-cycle pulse, then waits for end_fft (bounded
// by a timeout) before starting the next frame or going idle.
// Optional feature: define DROP_COUNT_EN to add the drop_cnt output, a
// saturating count of samples dropped while the FFT is launching or running.
// ADDR_WIDTH is expected to be in the range 3..15 so that it fits fft_size_sel.
module frame_dispatch #(
  parameter int ADDR_WIDTH  = 12,
  parameter int CORE_LAT    = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [3:0]            fft_size_sel,
  input  logic                  sample_valid,
  output logic                  wr_ena,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  ena_fft,
  output logic [ADDR_WIDTH-1:0] max_point_fft,
  output logic [15:0]           max_point_fft_core,
  output logic [3:0]            stage_number,
  input  logic                  end_fft,
  output logic                  busy,
  output logic                  overflow,
  output logic                  timeout_err,
`ifdef DROP_COUNT_EN
  output logic [15:0]           drop_cnt,
`endif
  output logic [15:0]           frame_cnt
);

  typedef enum logic [1:0] {IDLE, FILL, LAUNCH, BUSY} state_t;

  localparam logic [3:0]            MAX_SEL   = 4'(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] RST_MAXP  = ADDR_WIDTH'(7);
  localparam logic [15:0]           RST_CORE  = 16'(3 + CORE_LAT);
  localparam logic [15:0]           WAIT_LAST = 16'(TIMEOUT_CYC - 1);

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] count_q;
  logic [15:0]           wait_q;
  logic                  wr_ena_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic                  ena_fft_q;
  logic                  busy_q;
  logic                  overflow_q;
  logic                  timeout_err_q;
  logic [15:0]           frame_cnt_q;
  logic [3:0]            stage_q;
  logic [ADDR_WIDTH-1:0] max_point_q;
  logic [15:0]           core_q;

  // Clamped size and the configuration it implies, loaded on each FILL entry
  logic [3:0]            sel_d;
  logic [ADDR_WIDTH-1:0] max_point_d;
  logic [15:0]           core_d;
  logic                  idle_to_fill;
  logic                  dropping;
  logic                  done;

  // Derive the clamped frame configuration and shared event strobes
  always_comb begin
    sel_d = fft_size_sel;
    if (fft_size_sel < 4'd3) begin
      sel_d = 4'd3;
    end else if (fft_size_sel > MAX_SEL) begin
      sel_d = MAX_SEL;
    end
    max_point_d  = ADDR_WIDTH'((32'd1 << sel_d) - 32'd1);
    core_d       = 16'((32'd1 << (sel_d - 4'd1)) - 32'd1 + 32'(CORE_LAT));
    idle_to_fill = (state_q == IDLE) && enable;
    dropping     = ((state_q == LAUNCH) || (state_q == BUSY)) && sample_valid;
    // end_fft wins over a simultaneous timeout, so it counts as a clean finish
    done         = (state_q == BUSY) && (end_fft || (wait_q == WAIT_LAST));
  end

  // Main control FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      count_q       <= '0;
      wait_q        <= '0;
      wr_ena_q      <= 1'b0;
      wr_addr_q     <= '0;
      ena_fft_q     <= 1'b0;
      busy_q        <= 1'b0;
      overflow_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      frame_cnt_q   <= '0;
      stage_q       <= 4'd3;
      max_point_q   <= RST_MAXP;
      core_q        <= RST_CORE;
    end else begin
      wr_ena_q  <= 1'b0;
      ena_fft_q <= 1'b0;
      if (dropping) begin
        overflow_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          // Samples arriving while idle are silently ignored
          if (enable) begin
            state_q       <= FILL;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            stage_q       <= sel_d;
            max_point_q   <= max_point_d;
            core_q        <= core_d;
          end
        end
        FILL: begin
          if (!enable) begin
            // Abandon the partial frame; the next entry restarts at address 0
            state_q <= IDLE;
          end else if (sample_valid) begin
            wr_ena_q  <= 1'b1;
            wr_addr_q <= count_q;
            if (count_q == max_point_q) begin
              state_q     <= LAUNCH;
              ena_fft_q   <= 1'b1;
              busy_q      <= 1'b1;
              frame_cnt_q <= frame_cnt_q + 16'd1;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
        end
        LAUNCH: begin
          state_q <= BUSY;
          wait_q  <= '0;
        end
        BUSY: begin
          wait_q <= wait_q + 16'd1;
          if (done) begin
            busy_q <= 1'b0;
            if (!end_fft) begin
              timeout_err_q <= 1'b1;
            end
            if (enable) begin
              state_q     <= FILL;
              count_q     <= '0;
              stage_q     <= sel_d;
              max_point_q <= max_point_d;
              core_q      <= core_d;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DROP_COUNT_EN
  logic [15:0] drop_q;

  // Saturating dropped-sample counter, cleared together with overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (idle_to_fill) begin
      drop_q <= '0;
    end else if (dropping && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_cnt = drop_q;
`endif

  assign wr_ena             = wr_ena_q;
  assign wr_addr            = wr_addr_q;
  assign ena_fft            = ena_fft_q;
  assign busy               = busy_q;
  assign overflow           = overflow_q;
  assign timeout_err        = timeout_err_q;
  assign frame_cnt          = frame_cnt_q;
  assign stage_number       = stage_q;
  assign max_point_fft      = max_point_q;
  assign max_point_fft_core = core_q;

endmodule
